// File: rtl/switch_debounce_3ch.sv
// Three-channel switch conditioner: 2-flop synchroniser plus an independent
// debounce counter per channel, with registered one-cycle change pulses.
module switch_debounce_3ch #(
  parameter  int unsigned DEBOUNCE_CYCLES = 16,
  localparam int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sw_a,
  input  logic       sw_b,
  input  logic       sw_c,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic [2:0] chg,
  output logic       any_chg
);

  typedef enum logic {
    STABLE  = 1'b0,
    PENDING = 1'b1
  } chState_e;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Bit ordering everywhere matches chg: bit2=a, bit1=b, bit0=c.
  logic [2:0]       rawSw;
  logic [2:0]       sync1_q;
  logic [2:0]       sync2_q;
  logic [2:0]       stable_q;
  logic [2:0]       stable_d;
  logic [CNT_W-1:0] cnt_q [3];
  logic [CNT_W-1:0] cnt_d [3];
  logic [2:0]       chg_q;
  logic [2:0]       chg_d;
  logic             anyChg_q;
  logic             anyChg_d;
  chState_e         state [3];

  assign rawSw = {sw_a, sw_b, sw_c};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      chg_q    <= '0;
      anyChg_q <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q  <= rawSw;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      chg_q    <= chg_d;
      anyChg_q <= anyChg_d;
      for (int i = 0; i < 3; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // A channel is PENDING whenever its synchronised input disagrees with the
  // accepted value; any agreeing edge drops it back and restarts the window.
  always_comb begin
    stable_d = stable_q;
    chg_d    = '0;
    for (int i = 0; i < 3; i++) begin
      cnt_d[i] = '0;
      state[i] = (sync2_q[i] != stable_q[i]) ? PENDING : STABLE;
      case (state[i])
        PENDING: begin
          if (cnt_q[i] == CNT_MAX) begin
            stable_d[i] = sync2_q[i];
            chg_d[i]    = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end
        default: cnt_d[i] = '0;
      endcase
    end
    anyChg_d = |chg_d;
  end

  assign a       = stable_q[2];
  assign b       = stable_q[1];
  assign c       = stable_q[0];
  assign chg     = chg_q;
  assign any_chg = anyChg_q;

endmodule
